// File: rtl/subframe_pkg.sv
// Shared definitions for the subframe link (used by both transmit and receive sides).
package subframe_pkg;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  // Width of the running checksum; carries beyond this are discarded.
  localparam int SUM_W = 8;

  typedef enum logic [2:0] {
    ST_HUNT0 = 3'd0,
    ST_HUNT1 = 3'd1,
    ST_HDR   = 3'd2,
    ST_DATA  = 3'd3,
    ST_SUM   = 3'd4
  } deframe_state_t;

  // Modulo-2^SUM_W accumulate of one received byte.
  function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] acc,
                                               input logic [7:0]       b);
    logic [SUM_W-1:0] r;
    r = acc + SUM_W'(b);
    return r;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchronizer, start-bit glitch rejection and
// mid-bit sampling. Emits a one-cycle byte_valid at the stop-bit midpoint.
module uart_byte_rx #(
  parameter int CLK_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       stop_ok
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             sync1_q, sync2_q, prev_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic [7:0]       byte_q, byte_d;
  logic             stop_q, stop_d;

  assign byte_valid = valid_q;
  assign rx_byte    = byte_q;
  assign stop_ok    = stop_q;

  // Bring rx into the clock domain; prev_q gives a one-cycle-delayed copy for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Bit-timing state machine: counts to the start midpoint, then one full bit per sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    byte_d  = byte_q;
    stop_d  = stop_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = 3'd0;
          // A line already back high at mid-start is a glitch, not a byte.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      default: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          byte_d  = shift_q;
          stop_d  = sync2_q;
          // Back to idle at mid-stop so a directly following start bit is caught.
          state_d = RX_IDLE;
        end
      end
    endcase
  end

  // Register receiver control and the captured byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      valid_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      stop_q  <= stop_d;
    end
    shift_q <= shift_d;
    byte_q  <= byte_d;
  end

endmodule

// File: rtl/subframe_rx.sv
// Subframe deframer: hunts for A5 5A, validates the header, assembles
// MSB-first 32-bit words into write pulses, and checks the trailing sum.
module subframe_rx
  import subframe_pkg::*;
#(
  parameter int CLK_PER_BIT = 434,
  parameter int WORDS       = 64,
  parameter int GAP_BITS    = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  frame_cnt,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        frame_err
);

  localparam int GAP_LIMIT = GAP_BITS * CLK_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIMIT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_LIMIT - 1);
  localparam logic [7:0]       LAST_WORD = 8'(WORDS - 1);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       stop_ok;

  uart_byte_rx #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .stop_ok   (stop_ok)
  );

  deframe_state_t   state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [7:0]       widx_q, widx_d;
  logic [31:0]      shift_q, shift_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic             in_frame;

  assign in_frame   = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_SUM);

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_cnt  = cnt_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign frame_err  = err_q;

  // Deframer next state: sync hunt, header, payload words, checksum, and aborts.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    bcnt_d    = bcnt_q;
    widx_d    = widx_q;
    shift_d   = shift_q;
    gap_d     = in_frame ? gap_q + 1'b1 : '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    err_d     = 1'b0;

    if (byte_valid) begin
      gap_d = '0;
      case (state_q)
        ST_HUNT0: begin
          if (stop_ok && rx_byte == SYNC0) state_d = ST_HUNT1;
        end
        ST_HUNT1: begin
          // Repeated A5 keeps us armed so "A5 A5 5A" still locks.
          if (stop_ok) begin
            if (rx_byte == SYNC1)      state_d = ST_HDR;
            else if (rx_byte != SYNC0) state_d = ST_HUNT0;
          end
        end
        ST_HDR: begin
          if (!stop_ok || rx_byte[7:4] != 4'h0) begin
            err_d   = 1'b1;
            state_d = ST_HUNT0;
          end else begin
            cnt_d   = rx_byte[3:0];
            sum_d   = SUM_W'(rx_byte);
            bcnt_d  = 2'd0;
            widx_d  = 8'd0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (!stop_ok) begin
            err_d   = 1'b1;
            state_d = ST_HUNT0;
          end else begin
            shift_d = {shift_q[23:0], rx_byte};
            sum_d   = sum_add(sum_q, rx_byte);
            bcnt_d  = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              wr_en_d   = 1'b1;
              wr_addr_d = widx_q;
              wr_data_d = shift_d;
              if (widx_q == LAST_WORD) state_d = ST_SUM;
              else                     widx_d  = widx_q + 8'd1;
            end
          end
        end
        ST_SUM: begin
          if (!stop_ok) begin
            err_d   = 1'b1;
            state_d = ST_HUNT0;
          end else begin
            ok_d    = (rx_byte == sum_q);
            done_d  = 1'b1;
            state_d = ST_HUNT0;
          end
        end
        default: state_d = ST_HUNT0;
      endcase
    end else if (in_frame && gap_q == GAP_LAST) begin
      // Line went quiet mid-frame for too long.
      err_d   = 1'b1;
      gap_d   = '0;
      state_d = ST_HUNT0;
    end
  end

  // Register deframer control, outputs and the word/checksum accumulators.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_HUNT0;
      bcnt_q    <= 2'd0;
      widx_q    <= 8'd0;
      gap_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 32'd0;
      cnt_q     <= 4'd0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      widx_q    <= widx_d;
      gap_q     <= gap_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
    sum_q   <= sum_d;
    shift_q <= shift_d;
  end

endmodule

// File: tb/tb_subframe_rx.sv
// Directed bench for subframe_rx with WORDS=2, CLK_PER_BIT=16.
module tb_subframe_rx;

  localparam int C = 16;
  localparam int W = 2;
  localparam int G = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  frame_cnt;
  logic        frame_done;
  logic        frame_ok;
  logic        frame_err;

  subframe_rx #(.CLK_PER_BIT(C), .WORDS(W), .GAP_BITS(G)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_cnt (frame_cnt),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event log, sampled on the falling edge.
  int          wr_n = 0, done_n = 0, err_n = 0, overlap_n = 0;
  logic [7:0]  wa [64];
  logic [31:0] wd [64];
  int          wc [64];
  logic        last_ok = 1'b0;

  always @(negedge clock) begin
    if (wr_en) begin
      if (wr_n < 64) begin
        wa[wr_n] = wr_addr;
        wd[wr_n] = wr_data;
        wc[wr_n] = cyc;
      end
      wr_n++;
    end
    if (frame_done) begin
      done_n++;
      last_ok = frame_ok;
    end
    if (frame_err) err_n++;
    if (int'(wr_en) + int'(frame_done) + int'(frame_err) > 1) overlap_n++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int fcyc [64];

  // Caller must be at a falling clock edge; returns at one.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int idle_bits, input int idx);
    rx = 1'b0;
    fcyc[idx] = cyc;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clock);
    end
    rx = stop_bit;
    repeat (C) @(negedge clock);
    rx = 1'b1;
    repeat (idle_bits * C) @(negedge clock);
  endtask

  task automatic send_bytes(input logic [7:0] bs[$], input int bad_idx, input int stall_idx);
    foreach (bs[i]) begin
      if (i == bad_idx)        send_byte(bs[i], 1'b0, 2, i);
      else if (i == stall_idx) send_byte(bs[i], 1'b1, 21, i);
      else                     send_byte(bs[i], 1'b1, 0, i);
    end
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * C) @(negedge clock);
  endtask

  // Checksums hand-computed: 11+22+...+88 = 0x264, plus the header byte, mod 256.
  logic [7:0] f_good [$] = '{8'hA5, 8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h67};
  logic [7:0] f_bad  [$] = '{8'hA5, 8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h68};
  logic [7:0] f_hunt [$] = '{8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h69};
  logic [7:0] f_hdrx [$] = '{8'hA5, 8'h5A, 8'h13};
  logic [7:0] f_g6   [$] = '{8'hA5, 8'h5A, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h6A};
  logic [7:0] f_stop [$] = '{8'hA5, 8'h5A, 8'h03, 8'h11, 8'h22, 8'h33};
  logic [7:0] f_g2   [$] = '{8'hA5, 8'h5A, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h66};
  logic [7:0] f_tmo  [$] = '{8'hA5, 8'h5A, 8'h03, 8'h11, 8'h22};
  logic [7:0] f_g4   [$] = '{8'hA5, 8'h5A, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h68};
  logic [7:0] f_part [$] = '{8'hA5, 8'h5A, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] f_g9   [$] = '{8'hA5, 8'h5A, 8'h09, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h6D};

  int bw, bd, be;

  task automatic mark();
    bw = wr_n;
    bd = done_n;
    be = err_n;
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    idle(2);

    // Good frame
    mark();
    send_bytes(f_good, -1, -1);
    idle(3);
    check("good_wr_count", 32'(wr_n - bw), 32'd2);
    check("good_addr0", 32'(wa[bw]), 32'd0);
    check("good_data0", wd[bw], 32'h11223344);
    check("good_addr1", 32'(wa[bw+1]), 32'd1);
    check("good_data1", wd[bw+1], 32'h55667788);
    check("good_latency", 32'(wc[bw] - fcyc[6]), 32'(1 + (2 + C/2 + 9*C) + 1));
    check("good_cnt", 32'(frame_cnt), 32'd3);
    check("good_done", 32'(done_n - bd), 32'd1);
    check("good_ok", 32'(last_ok), 32'd1);
    check("good_ok_held", 32'(frame_ok), 32'd1);
    check("good_err", 32'(err_n - be), 32'd0);

    // Corrupt checksum
    mark();
    send_bytes(f_bad, -1, -1);
    idle(3);
    check("csum_wr_count", 32'(wr_n - bw), 32'd2);
    check("csum_data1", wd[bw+1], 32'h55667788);
    check("csum_done", 32'(done_n - bd), 32'd1);
    check("csum_ok", 32'(last_ok), 32'd0);

    // Sync hunting through garbage
    mark();
    send_bytes(f_hunt, -1, -1);
    idle(3);
    check("hunt_done", 32'(done_n - bd), 32'd1);
    check("hunt_ok", 32'(last_ok), 32'd1);
    check("hunt_err", 32'(err_n - be), 32'd0);
    check("hunt_cnt", 32'(frame_cnt), 32'd5);
    check("hunt_data0", wd[bw], 32'h11223344);

    // Bad header nibble, then a good frame
    mark();
    send_bytes(f_hdrx, -1, -1);
    idle(2);
    check("hdr_err", 32'(err_n - be), 32'd1);
    check("hdr_no_wr", 32'(wr_n - bw), 32'd0);
    mark();
    send_bytes(f_g6, -1, -1);
    idle(3);
    check("hdr_next_done", 32'(done_n - bd), 32'd1);
    check("hdr_next_ok", 32'(last_ok), 32'd1);
    check("hdr_next_cnt", 32'(frame_cnt), 32'd6);

    // Stop bit low on the third payload byte, then a good frame
    mark();
    send_bytes(f_stop, 5, -1);
    check("stop_err", 32'(err_n - be), 32'd1);
    check("stop_no_done", 32'(done_n - bd), 32'd0);
    mark();
    send_bytes(f_g2, -1, -1);
    idle(3);
    check("stop_next_done", 32'(done_n - bd), 32'd1);
    check("stop_next_ok", 32'(last_ok), 32'd1);
    check("stop_next_wr", 32'(wr_n - bw), 32'd2);
    check("stop_next_err", 32'(err_n - be), 32'd0);

    // Stall 21 bit-times after byte 5
    mark();
    send_bytes(f_tmo, -1, 4);
    check("tmo_err", 32'(err_n - be), 32'd1);
    check("tmo_no_done", 32'(done_n - bd), 32'd0);
    mark();
    send_bytes(f_g4, -1, -1);
    idle(3);
    check("tmo_next_done", 32'(done_n - bd), 32'd1);
    check("tmo_next_ok", 32'(last_ok), 32'd1);

    // Reset in the middle of a byte mid-payload
    send_bytes(f_part, -1, -1);
    rx = 1'b0;
    repeat (3 * C) @(negedge clock);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(negedge clock);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", wr_data, 32'd0);
    check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_done", 32'(frame_done), 32'd0);
    check("mid_rst_ok", 32'(frame_ok), 32'd0);
    check("mid_rst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    idle(2);
    mark();
    send_bytes(f_g9, -1, -1);
    idle(3);
    check("rst_next_wr", 32'(wr_n - bw), 32'd2);
    check("rst_next_data0", wd[bw], 32'h11223344);
    check("rst_next_data1", wd[bw+1], 32'h55667788);
    check("rst_next_done", 32'(done_n - bd), 32'd1);
    check("rst_next_ok", 32'(last_ok), 32'd1);
    check("rst_next_cnt", 32'(frame_cnt), 32'd9);
    check("rst_next_err", 32'(err_n - be), 32'd0);

    check("pulse_overlap", 32'(overlap_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
